// File: rtl/ps2_map_pkg.sv
// Shared types for the PS/2 keyboard-to-button mapper.
//   map_entry_t  : one key map entry {valid, ext, code, btn_idx}
//   ps2_event_t  : a captured key event {pressed, ext, code}
//   state_t      : scan FSM states
//   TOGGLE/PRESSED/EXT : bit positions inside the 11-bit ps2_key word
package ps2_map_pkg;

  localparam int unsigned TOGGLE  = 10;
  localparam int unsigned PRESSED = 9;
  localparam int unsigned EXT     = 8;

  // Wide enough for the largest supported button count (64).
  localparam int unsigned IDX_W = 6;

  typedef struct packed {
    logic             valid;
    logic             ext;
    logic [7:0]       code;
    logic [IDX_W-1:0] btn_idx;
  } map_entry_t;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/ps2_map_table.sv
// Key map register file: MAP_DEPTH entries, one synchronous write port and
// one combinational read port driven by the scan FSM.
//   clk_sys, reset : clock, async active-high reset (all entries invalid)
//   wr, wr_addr, wr_entry : write strobe, index, entry
//   rd_addr, rd_entry     : combinational read
module ps2_map_table
  import ps2_map_pkg::*;
#(
  parameter int unsigned MAP_DEPTH = 32,
  localparam int unsigned AW = $clog2(MAP_DEPTH)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  map_entry_t    wr_entry,
  input  logic [AW-1:0] rd_addr,
  output map_entry_t    rd_entry
);

  map_entry_t entries [MAP_DEPTH];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      entries <= '{default: '0};
    end else if (wr) begin
      entries[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = entries[rd_addr];

endmodule

// File: rtl/ps2_button_mapper.sv
// Programmable PS/2 key to arcade button mapper.
//   clk_sys  : system clock          reset    : async active-high reset
//   ps2_key  : {toggle, pressed, ext, code[7:0]} from hps_io
//   map_wr/map_addr/map_data : key map load port {valid, ext, code, btn_idx}
//   af_en    : per-button autofire enable
//   clear    : synchronous release of all buttons, drops pending/in-flight work
//   btn      : registered button outputs
//   busy     : a map scan is in progress
//   overflow : sticky, an event was dropped because pending was full
// Each event is applied by walking every map entry once; matches bump a
// saturating 2-bit reference count per button so shared buttons survive a
// partial release.
module ps2_button_mapper
  import ps2_map_pkg::*;
#(
  parameter int unsigned         NUM_BTN    = 32,
  parameter int unsigned         MAP_DEPTH  = 32,
  parameter int unsigned         PULSE_LEN  = 4000,
  parameter logic [NUM_BTN-1:0]  PULSE_MASK = '0,
  parameter int unsigned         AF_PERIOD  = 1000000,
  localparam int unsigned AW  = $clog2(MAP_DEPTH),
  localparam int unsigned BW  = $clog2(NUM_BTN),
  localparam int unsigned PW  = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1,
  localparam int unsigned AFW = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [10:0]        ps2_key,
  input  logic               map_wr,
  input  logic [AW-1:0]      map_addr,
  input  logic [BW+9:0]      map_data,
  input  logic [NUM_BTN-1:0] af_en,
  input  logic               clear,
  output logic [NUM_BTN-1:0] btn,
  output logic               busy,
  output logic               overflow
);

  // Event capture. tog_init suppresses the compare on the first clock after
  // reset so whatever level ps2_key[10] sits at is not taken as an event.
  logic       tog_q, tog_init, new_ev, consume;
  logic       pend_valid;
  ps2_event_t pend_q, ev_q;

  assign new_ev = tog_init && (ps2_key[TOGGLE] != tog_q);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q      <= 1'b0;
      tog_init   <= 1'b0;
      pend_valid <= 1'b0;
      pend_q     <= '0;
      overflow   <= 1'b0;
    end else begin
      tog_q    <= ps2_key[TOGGLE];
      tog_init <= 1'b1;
      if (clear) begin
        pend_valid <= 1'b0;
        overflow   <= 1'b0;
      end else if (new_ev) begin
        // A slot freed by this cycle's consume is reusable immediately.
        if (!pend_valid || consume) begin
          pend_valid <= 1'b1;
          pend_q     <= '{pressed: ps2_key[PRESSED], ext: ps2_key[EXT],
                          code: ps2_key[7:0]};
        end else begin
          overflow <= 1'b1;
        end
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Scan FSM
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (consume) ev_q <= pend_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid) begin
          consume = 1'b1;
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == AW'(MAP_DEPTH - 1)) state_d = IDLE;
        else                             idx_d   = idx_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      consume = 1'b0;
    end
  end

  assign busy = (state_q == SCAN);

  // Map table and match
  map_entry_t wr_entry, rd_entry;
  logic       hit;

  assign wr_entry = '{valid: map_data[BW+9], ext: map_data[BW+8],
                      code: map_data[BW+7 -: 8],
                      btn_idx: IDX_W'(map_data[BW-1:0])};

  ps2_map_table #(.MAP_DEPTH(MAP_DEPTH)) u_table (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .wr       (map_wr),
    .wr_addr  (map_addr),
    .wr_entry (wr_entry),
    .rd_addr  (idx_q),
    .rd_entry (rd_entry)
  );

  assign hit = busy && rd_entry.valid && (rd_entry.ext == ev_q.ext) &&
               (rd_entry.code == ev_q.code);

  // Saturating reference counts
  logic [1:0]         refcnt [NUM_BTN];
  logic [NUM_BTN-1:0] held, stretched;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      refcnt <= '{default: '0};
    end else if (clear) begin
      refcnt <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (hit && rd_entry.btn_idx == IDX_W'(i)) begin
          if (ev_q.pressed) begin
            if (refcnt[i] != 2'd3) refcnt[i] <= refcnt[i] + 2'd1;
          end else begin
            if (refcnt[i] != 2'd0) refcnt[i] <= refcnt[i] - 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    held = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) held[i] = (refcnt[i] != 2'd0);
  end

  // Pulse stretching, only instantiated for masked buttons
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    if (PULSE_MASK[g]) begin : g_pulse
      logic [PW-1:0] pcnt;
      logic          held_d;
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          pcnt   <= '0;
          held_d <= 1'b0;
        end else if (clear) begin
          pcnt   <= '0;
          held_d <= 1'b0;
        end else begin
          held_d <= held[g];
          if (held[g] && !held_d)  pcnt <= PW'(PULSE_LEN - 1);
          else if (pcnt != '0)     pcnt <= pcnt - PW'(1);
        end
      end
      assign stretched[g] = held[g] | (pcnt != '0);
    end else begin : g_plain
      assign stretched[g] = held[g];
    end
  end

  // Autofire phase, shared by all buttons
  logic [AFW-1:0] af_cnt;
  logic           af_phase;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AFW'(AF_PERIOD - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + AFW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)      btn <= '0;
    else if (clear) btn <= '0;
    else            btn <= stretched & (~af_en | {NUM_BTN{af_phase}});
  end

endmodule

// File: tb/tb_ps2_button_mapper.sv
module tb_ps2_button_mapper;

  localparam int unsigned NB  = 8;
  localparam int unsigned MD  = 32;
  localparam int unsigned PL  = 100;
  localparam int unsigned AFP = 10;
  localparam logic [NB-1:0] PM = 8'h80;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic [10:0]   ps2_key = '0;
  logic          map_wr  = 1'b0;
  logic [4:0]    map_addr = '0;
  logic [12:0]   map_data = '0;
  logic [NB-1:0] af_en   = '0;
  logic          clear   = 1'b0;
  logic [NB-1:0] btn;
  logic          busy, overflow;

  ps2_button_mapper #(
    .NUM_BTN   (NB),
    .MAP_DEPTH (MD),
    .PULSE_LEN (PL),
    .PULSE_MASK(PM),
    .AF_PERIOD (AFP)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .map_wr   (map_wr),
    .map_addr (map_addr),
    .map_data (map_data),
    .af_en    (af_en),
    .clear    (clear),
    .btn      (btn),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference model: the key map as plain records and integer ref counts.
  typedef struct {
    bit       valid;
    bit       ext;
    bit [7:0] code;
    int       b;
  } mentry_t;

  mentry_t       mmap [MD];
  int            mref [NB];
  logic [NB-1:0] expq [$];
  logic [NB-1:0] sb_mask = '1;
  bit            sb_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] model_btns();
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i] = (mref[i] != 0);
    return r;
  endfunction

  task automatic model_event(input bit pressed, input bit ext,
                             input bit [7:0] code);
    for (int i = 0; i < MD; i++) begin
      if (mmap[i].valid && mmap[i].ext == ext && mmap[i].code == code) begin
        if (pressed) mref[mmap[i].b] = (mref[mmap[i].b] >= 3) ? 3 : mref[mmap[i].b] + 1;
        else         mref[mmap[i].b] = (mref[mmap[i].b] <= 0) ? 0 : mref[mmap[i].b] - 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MD; i++) mmap[i] = '{valid: 1'b0, ext: 1'b0, code: 8'h00, b: 0};
    for (int i = 0; i < NB; i++) mref[i] = 0;
  endtask

  task automatic write_map(input int addr, input bit v, input bit ext,
                           input bit [7:0] code, input int b);
    @(negedge clk_sys);
    map_wr   = 1'b1;
    map_addr = addr[4:0];
    map_data = {v, ext, code, b[2:0]};
    mmap[addr] = '{valid: v, ext: ext, code: code, b: b};
    @(negedge clk_sys);
    map_wr = 1'b0;
  endtask

  // Issues one key event immediately; accepted events push their expected
  // button vector for the monitor.
  task automatic send(input bit pressed, input bit ext, input bit [7:0] code,
                      input bit accept);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    if (accept) begin
      model_event(pressed, ext, code);
      expq.push_back(model_btns());
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, 64'(n >= 400), 64'd0);
  endtask

  // Monitor: one comparison per completed scan, taken once btn has updated.
  logic busy_prev = 1'b0;
  bit   cmp_next  = 1'b0;

  always @(negedge clk_sys) begin
    logic [NB-1:0] e;
    if (reset || !sb_en) begin
      busy_prev = 1'b0;
      cmp_next  = 1'b0;
    end else begin
      if (cmp_next) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_scan: got scan end with empty queue, required none");
        end else begin
          e = expq.pop_front();
          check("sb_btn", 64'(btn & sb_mask), 64'(e & sb_mask));
        end
      end
      cmp_next  = busy_prev && !busy;
      busy_prev = busy;
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n, hi, len;
    logic cur;
    bit seen;

    model_reset();
    ps2_key[10] = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("reset_btn", 64'(btn), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;

    // Tracker starts from the current toggle level: no scan may start.
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_sys);
      if (busy) seen = 1'b1;
    end
    check("no_spurious_event", 64'(seen), 64'd0);

    // Single key press/release with latency bound.
    write_map(0, 1, 0, 8'h29, 4);
    @(negedge clk_sys);
    send(1, 0, 8'h29, 1);
    n = 0;
    while (!btn[4] && n < MD + 2) begin
      @(negedge clk_sys);
      n++;
    end
    check("t1_press_latency", 64'(btn[4]), 64'd1);
    drain("t1_press_drain");
    send(0, 0, 8'h29, 1);
    drain("t1_release_drain");
    check("t1_release_btn4", 64'(btn[4]), 64'd0);

    // Two keys sharing one button.
    write_map(1, 1, 0, 8'h14, 4);
    send(1, 0, 8'h29, 1); drain("t2_a");
    send(1, 0, 8'h14, 1); drain("t2_b");
    send(0, 0, 8'h29, 1); drain("t2_c");
    check("t2_shared_hold", 64'(btn[4]), 64'd1);
    send(0, 0, 8'h14, 1); drain("t2_d");
    check("t2_shared_release", 64'(btn[4]), 64'd0);

    // Pulse stretching on btn 7.
    sb_mask = 8'h7F;
    write_map(2, 1, 0, 8'h2E, 7);
    @(negedge clk_sys);
    send(1, 0, 8'h2E, 1);
    n = 0;
    while (!btn[7] && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("pulse_rise", 64'(btn[7]), 64'd1);
    hi = 0;
    n  = 0;
    while (btn[7] && n < 300) begin
      hi++;
      if (n == 5) send(0, 0, 8'h2E, 1);
      @(negedge clk_sys);
      n++;
    end
    check("pulse_len", 64'(hi), 64'(PL));
    drain("pulse_drain");
    sb_mask = '1;

    // Three back-to-back events: third dropped.
    write_map(3, 1, 0, 8'h16, 1);
    write_map(4, 1, 0, 8'h1E, 2);
    @(negedge clk_sys);
    send(1, 0, 8'h29, 1);
    @(negedge clk_sys);
    send(1, 0, 8'h16, 1);
    @(negedge clk_sys);
    send(1, 0, 8'h1E, 0);
    drain("ovf_drain");
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_dropped_btn2", 64'(btn[2]), 64'd0);
    clear = 1'b1;
    for (int i = 0; i < NB; i++) mref[i] = 0;
    @(negedge clk_sys);
    clear = 1'b0;
    check("clear_overflow", 64'(overflow), 64'd0);
    check("clear_btn", 64'(btn), 64'd0);

    // Autofire on btn 4.
    af_en   = 8'h10;
    sb_mask = 8'hEF;
    send(1, 0, 8'h29, 1);
    n = 0;
    while (!btn[4] && n < 60) begin
      @(negedge clk_sys);
      n++;
    end
    check("af_rise", 64'(btn[4]), 64'd1);
    cur = btn[4];
    for (int r = 0; r < 5; r++) begin
      len = 0;
      while (btn[4] == cur && len < 50) begin
        @(negedge clk_sys);
        len++;
      end
      if (r > 0) check("af_half_period", 64'(len), 64'(AFP));
      cur = ~cur;
    end
    send(0, 0, 8'h29, 1);
    n = 0;
    while (!busy && n < 5) begin @(negedge clk_sys); n++; end
    n = 0;
    while (busy && n < 60) begin @(negedge clk_sys); n++; end
    repeat (2) @(negedge clk_sys);
    check("af_release", 64'(btn[4]), 64'd0);
    drain("af_drain");
    af_en   = '0;
    sb_mask = '1;

    // Extended vs plain scancode.
    write_map(5, 1, 1, 8'h75, 0);
    send(1, 0, 8'h75, 1); drain("ext_plain_drain");
    check("ext_plain_btn0", 64'(btn[0]), 64'd0);
    send(1, 1, 8'h75, 1); drain("ext_e0_drain");
    check("ext_e0_btn0", 64'(btn[0]), 64'd1);

    // Asynchronous reset in the middle of a scan.
    sb_en = 1'b0;
    expq.delete();
    send(1, 0, 8'h29, 0);
    repeat (5) @(negedge clk_sys);
    check("midscan_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_btn", 64'(btn), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_overflow", 64'(overflow), 64'd0);
    model_reset();
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    sb_en = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Randomized map and event stream.
    for (int i = 0; i < MD; i++) begin
      write_map(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                8'h10 + 8'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
    end
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      n = 0;
      while (expq.size() >= 2 && n < 200) begin
        @(negedge clk_sys);
        n++;
      end
      send(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
           8'h10 + 8'($urandom_range(0, 7)), 1);
      @(negedge clk_sys);
    end
    drain("rand_drain");
    check("rand_final_btn", 64'(btn), 64'(model_btns()));
    check("rand_no_overflow", 64'(overflow), 64'd0);

    repeat (5) @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
